// File: rtl/tagged_checkpoint_register_file.sv
// tagged_checkpoint_register_file: multi-port register file with per-register valid/ROB-tag
// scoreboard, same-cycle forwarding and checkpointed valid+tag maps for mispredict recovery.
module tagged_checkpoint_register_file #(
   parameter int DATA_WIDTH       = 32,
   parameter int NUM_REGISTERS    = 64,
   parameter int ADDR_WIDTH       = $clog2(NUM_REGISTERS),
   parameter int NUM_READ_PORTS   = 6,
   parameter int NUM_ALLOC_PORTS  = 3,
   parameter int NUM_COMMIT_PORTS = 3,
   parameter int TAG_WIDTH        = 5,
   parameter int NUM_CHECKPOINTS  = 4,
   parameter int CKPT_W           = (NUM_CHECKPOINTS > 1) ? $clog2(NUM_CHECKPOINTS) : 1
) (
   input  logic                                             clk_i,
   input  logic                                             rst_ni,
   input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]        read_addr_i,
   output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]        read_data_o,
   output logic [NUM_READ_PORTS-1:0]                        read_valid_o,
   output logic [NUM_READ_PORTS-1:0][TAG_WIDTH-1:0]         read_tag_o,
   input  logic [NUM_ALLOC_PORTS-1:0]                       alloc_enable_i,
   input  logic [NUM_ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]       alloc_addr_i,
   input  logic [NUM_ALLOC_PORTS-1:0][TAG_WIDTH-1:0]        alloc_tag_i,
   input  logic [NUM_COMMIT_PORTS-1:0]                      commit_enable_i,
   input  logic [NUM_COMMIT_PORTS-1:0][ADDR_WIDTH-1:0]      commit_addr_i,
   input  logic [NUM_COMMIT_PORTS-1:0][TAG_WIDTH-1:0]       commit_tag_i,
   input  logic [NUM_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]      commit_data_i,
   input  logic                                             ckpt_save_i,
   input  logic [CKPT_W-1:0]                                ckpt_save_id_i,
   input  logic                                             ckpt_restore_i,
   input  logic [CKPT_W-1:0]                                ckpt_restore_id_i,
   input  logic                                             ckpt_release_i,
   input  logic [CKPT_W-1:0]                                ckpt_release_id_i,
   input  logic                                             flush_all_i,
   output logic [NUM_CHECKPOINTS-1:0]                       ckpt_valid_o,
   output logic                                             restore_error_o
);

   logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0]                       data_q, data_d;
   logic [NUM_REGISTERS-1:0]                                       valid_q, valid_d;
   logic [NUM_REGISTERS-1:0][TAG_WIDTH-1:0]                        tag_q, tag_d;
   logic [NUM_CHECKPOINTS-1:0][NUM_REGISTERS-1:0]                  ckpt_vmap_q, ckpt_vmap_d;
   logic [NUM_CHECKPOINTS-1:0][NUM_REGISTERS-1:0][TAG_WIDTH-1:0]   ckpt_tag_q, ckpt_tag_d;
   logic [NUM_CHECKPOINTS-1:0]                                     ckpt_valid_q, ckpt_valid_d;
   // age_q[i][j] = 1 when slot j was saved after slot i
   logic [NUM_CHECKPOINTS-1:0][NUM_CHECKPOINTS-1:0]                age_q, age_d;
   logic                                                           restore_error_q, restore_error_d;
   logic                                                           restore_ok, alloc_ok, save_ok;

   always_comb begin
      restore_ok      = ckpt_restore_i && ckpt_valid_q[ckpt_restore_id_i] && !flush_all_i;
      restore_error_d = ckpt_restore_i && !ckpt_valid_q[ckpt_restore_id_i] && !flush_all_i;
      alloc_ok        = !flush_all_i && !restore_ok;
      save_ok         = ckpt_save_i && alloc_ok;
      data_d          = data_q;
      valid_d         = restore_ok ? ckpt_vmap_q[ckpt_restore_id_i] : valid_q;
      tag_d           = restore_ok ? ckpt_tag_q[ckpt_restore_id_i] : tag_q;
      ckpt_vmap_d     = ckpt_vmap_q;
      ckpt_tag_d      = ckpt_tag_q;
      ckpt_valid_d    = ckpt_valid_q;
      age_d           = age_q;
      // commits compare against the base map (stored or restored) before allocates overwrite it
      for (int c = 0; c < NUM_COMMIT_PORTS; c++) begin
         if (commit_enable_i[c] && commit_addr_i[c] != '0) begin
            data_d[commit_addr_i[c]] = commit_data_i[c];
            if (tag_d[commit_addr_i[c]] == commit_tag_i[c]) valid_d[commit_addr_i[c]] = 1'b1;
            for (int s = 0; s < NUM_CHECKPOINTS; s++)
               if (ckpt_valid_q[s] && ckpt_tag_q[s][commit_addr_i[c]] == commit_tag_i[c])
                  ckpt_vmap_d[s][commit_addr_i[c]] = 1'b1;
         end
      end
      for (int p = 0; p < NUM_ALLOC_PORTS; p++) begin
         if (alloc_ok && alloc_enable_i[p] && alloc_addr_i[p] != '0) begin
            valid_d[alloc_addr_i[p]] = 1'b0;
            tag_d[alloc_addr_i[p]]   = alloc_tag_i[p];
         end
      end
      if (flush_all_i) valid_d = '1;
      if (ckpt_release_i) ckpt_valid_d[ckpt_release_id_i] = 1'b0;
      if (save_ok) begin
         ckpt_vmap_d[ckpt_save_id_i]  = valid_d;
         ckpt_tag_d[ckpt_save_id_i]   = tag_d;
         ckpt_valid_d[ckpt_save_id_i] = 1'b1;
         age_d[ckpt_save_id_i]        = '0;
         for (int s = 0; s < NUM_CHECKPOINTS; s++)
            if (CKPT_W'(s) != ckpt_save_id_i) age_d[s][ckpt_save_id_i] = 1'b1;
      end
      if (restore_ok) begin
         ckpt_valid_d[ckpt_restore_id_i] = 1'b0;
         for (int s = 0; s < NUM_CHECKPOINTS; s++)
            if (age_q[ckpt_restore_id_i][s]) ckpt_valid_d[s] = 1'b0;
      end
      if (flush_all_i) ckpt_valid_d = '0;
   end

   always_comb begin
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
         read_data_o[r]  = data_q[read_addr_i[r]];
         read_valid_o[r] = valid_q[read_addr_i[r]];
         read_tag_o[r]   = tag_q[read_addr_i[r]];
         for (int c = 0; c < NUM_COMMIT_PORTS; c++) begin
            if (commit_enable_i[c] && commit_addr_i[c] == read_addr_i[r]) begin
               read_data_o[r]  = commit_data_i[c];
               read_valid_o[r] = (tag_q[read_addr_i[r]] == commit_tag_i[c]) ? 1'b1 : valid_q[read_addr_i[r]];
            end
         end
         for (int p = 0; p < NUM_ALLOC_PORTS; p++) begin
            if (alloc_enable_i[p] && alloc_addr_i[p] == read_addr_i[r]) begin
               read_valid_o[r] = 1'b0;
               read_tag_o[r]   = alloc_tag_i[p];
            end
         end
         if (read_addr_i[r] == '0) begin
            read_data_o[r]  = '0;
            read_valid_o[r] = 1'b1;
            read_tag_o[r]   = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q          <= '0;
         valid_q         <= '1;
         tag_q           <= '0;
         ckpt_vmap_q     <= '1;
         ckpt_tag_q      <= '0;
         ckpt_valid_q    <= '0;
         age_q           <= '0;
         restore_error_q <= 1'b0;
      end else begin
         data_q          <= data_d;
         valid_q         <= valid_d;
         tag_q           <= tag_d;
         ckpt_vmap_q     <= ckpt_vmap_d;
         ckpt_tag_q      <= ckpt_tag_d;
         ckpt_valid_q    <= ckpt_valid_d;
         age_q           <= age_d;
         restore_error_q <= restore_error_d;
      end
   end

   assign ckpt_valid_o    = ckpt_valid_q;
   assign restore_error_o = restore_error_q;

endmodule

// File: tb/tb_tagged_checkpoint_register_file.sv
// tb_tagged_checkpoint_register_file: directed stimulus, per-cycle comparison against an
// array/sequence-number model of the register map, plus hand-computed literal expectations.
module tb_tagged_checkpoint_register_file;
   localparam int DW = 32, NR = 64, AW = 6, NRP = 6, NAP = 3, NCP = 3, TW = 5, NCK = 4, CW = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [NRP-1:0][AW-1:0] read_addr;
   logic [NRP-1:0][DW-1:0] read_data;
   logic [NRP-1:0]         read_valid;
   logic [NRP-1:0][TW-1:0] read_tag;
   logic [NAP-1:0]         alloc_en;
   logic [NAP-1:0][AW-1:0] alloc_addr;
   logic [NAP-1:0][TW-1:0] alloc_tag;
   logic [NCP-1:0]         commit_en;
   logic [NCP-1:0][AW-1:0] commit_addr;
   logic [NCP-1:0][TW-1:0] commit_tag;
   logic [NCP-1:0][DW-1:0] commit_data;
   logic                   save, restore, release_c, flush;
   logic [CW-1:0]          save_id, restore_id, release_id;
   logic [NCK-1:0]         ckpt_valid;
   logic                   restore_error;

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   tagged_checkpoint_register_file dut (
      .clk_i(clk), .rst_ni(rst_n),
      .read_addr_i(read_addr), .read_data_o(read_data), .read_valid_o(read_valid), .read_tag_o(read_tag),
      .alloc_enable_i(alloc_en), .alloc_addr_i(alloc_addr), .alloc_tag_i(alloc_tag),
      .commit_enable_i(commit_en), .commit_addr_i(commit_addr), .commit_tag_i(commit_tag),
      .commit_data_i(commit_data),
      .ckpt_save_i(save), .ckpt_save_id_i(save_id),
      .ckpt_restore_i(restore), .ckpt_restore_id_i(restore_id),
      .ckpt_release_i(release_c), .ckpt_release_id_i(release_id),
      .flush_all_i(flush), .ckpt_valid_o(ckpt_valid), .restore_error_o(restore_error)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_data[NR];
   bit            m_valid[NR];
   logic [TW-1:0] m_tag[NR];
   bit            cv[NCK][NR];
   logic [TW-1:0] ct[NCK][NR];
   bit            ckv[NCK];
   int            seq[NCK];
   int            seq_ctr;
   bit            rerr;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_data[i] = '0; m_valid[i] = 1'b1; m_tag[i] = '0;
         for (int s = 0; s < NCK; s++) begin cv[s][i] = 1'b1; ct[s][i] = '0; end
      end
      for (int s = 0; s < NCK; s++) begin ckv[s] = 1'b0; seq[s] = 0; end
      seq_ctr = 0;
      rerr = 1'b0;
   endtask

   task automatic model_compare();
      for (int r = 0; r < NRP; r++) begin
         int a;
         logic [DW-1:0] ed;
         bit ev;
         logic [TW-1:0] et;
         a = int'(read_addr[r]);
         ed = m_data[a]; ev = m_valid[a]; et = m_tag[a];
         for (int c = 0; c < NCP; c++)
            if (commit_en[c] && int'(commit_addr[c]) == a) begin
               ed = commit_data[c];
               ev = (m_tag[a] == commit_tag[c]) ? 1'b1 : m_valid[a];
            end
         for (int p = 0; p < NAP; p++)
            if (alloc_en[p] && int'(alloc_addr[p]) == a) begin ev = 1'b0; et = alloc_tag[p]; end
         if (a == 0) begin ed = '0; ev = 1'b1; et = '0; end
         chk($sformatf("model_rd%0d_data", r), read_data[r], ed);
         chk($sformatf("model_rd%0d_valid", r), 32'(read_valid[r]), 32'(ev));
         if (!ev) chk($sformatf("model_rd%0d_tag", r), 32'(read_tag[r]), 32'(et));
      end
      chk("model_ckpt_valid", 32'(ckpt_valid), 32'({ckv[3], ckv[2], ckv[1], ckv[0]}));
      chk("model_restore_error", 32'(restore_error), 32'(rerr));
   endtask

   task automatic model_advance();
      bit nv[NR];
      logic [TW-1:0] nt[NR];
      bit rok;
      int rid, sid, a;
      rid = int'(restore_id);
      sid = int'(save_id);
      rok  = restore && ckv[rid] && !flush;
      rerr = restore && !ckv[rid] && !flush;
      for (int i = 0; i < NR; i++) begin
         nv[i] = rok ? cv[rid][i] : m_valid[i];
         nt[i] = rok ? ct[rid][i] : m_tag[i];
      end
      for (int c = 0; c < NCP; c++)
         if (commit_en[c] && commit_addr[c] != 0) begin
            a = int'(commit_addr[c]);
            m_data[a] = commit_data[c];
            if (nt[a] == commit_tag[c]) nv[a] = 1'b1;
            for (int s = 0; s < NCK; s++)
               if (ckv[s] && ct[s][a] == commit_tag[c]) cv[s][a] = 1'b1;
         end
      if (!flush && !rok)
         for (int p = 0; p < NAP; p++)
            if (alloc_en[p] && alloc_addr[p] != 0) begin
               nv[int'(alloc_addr[p])] = 1'b0;
               nt[int'(alloc_addr[p])] = alloc_tag[p];
            end
      if (release_c) ckv[int'(release_id)] = 1'b0;
      if (flush) begin
         for (int i = 0; i < NR; i++) nv[i] = 1'b1;
         for (int s = 0; s < NCK; s++) ckv[s] = 1'b0;
      end else if (rok) begin
         int base;
         base = seq[rid];
         for (int s = 0; s < NCK; s++) if (s == rid || seq[s] > base) ckv[s] = 1'b0;
      end else if (save) begin
         for (int i = 0; i < NR; i++) begin cv[sid][i] = nv[i]; ct[sid][i] = nt[i]; end
         ckv[sid] = 1'b1;
         seq_ctr++;
         seq[sid] = seq_ctr;
      end
      for (int i = 0; i < NR; i++) begin m_valid[i] = nv[i]; m_tag[i] = nt[i]; end
   endtask

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      model_compare();
      if (rst_n) model_advance();
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      alloc_en = '0; alloc_addr = '0; alloc_tag = '0;
      commit_en = '0; commit_addr = '0; commit_tag = '0; commit_data = '0;
      save = 1'b0; save_id = '0; restore = 1'b0; restore_id = '0;
      release_c = 1'b0; release_id = '0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      read_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // reset values and commit with no prior allocate
      read_addr[0] = 6'd5;
      #2;
      chk("x5_reset_data", read_data[0], 32'h0);
      chk("x5_reset_valid", 32'(read_valid[0]), 32'd1);
      chk("x5_reset_tag", 32'(read_tag[0]), 32'd0);
      tick();
      commit_en[0] = 1'b1; commit_addr[0] = 6'd5; commit_tag[0] = 5'd3; commit_data[0] = 32'hDEADBEEF;
      tick();
      #2;
      chk("x5_commit_data", read_data[0], 32'hDEADBEEF);
      chk("x5_commit_valid", 32'(read_valid[0]), 32'd1);
      // same-address allocates: highest port wins; stale commit is WAW
      tick();
      alloc_en = 3'b101;
      alloc_addr[0] = 6'd7; alloc_tag[0] = 5'd4;
      alloc_addr[2] = 6'd7; alloc_tag[2] = 5'd9;
      read_addr[1] = 6'd7;
      #2;
      chk("x7_fwd_valid", 32'(read_valid[1]), 32'd0);
      chk("x7_fwd_tag", 32'(read_tag[1]), 32'd9);
      tick();
      commit_en[1] = 1'b1; commit_addr[1] = 6'd7; commit_tag[1] = 5'd4; commit_data[1] = 32'h11;
      tick();
      #2;
      chk("x7_waw_data", read_data[1], 32'h11);
      chk("x7_waw_valid", 32'(read_valid[1]), 32'd0);
      chk("x7_waw_tag", 32'(read_tag[1]), 32'd9);
      // checkpoint picks up a later commit before restore
      tick();
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd3; alloc_tag[0] = 5'd2;
      save = 1'b1; save_id = 2'd1;
      read_addr[2] = 6'd3;
      tick();
      commit_en[0] = 1'b1; commit_addr[0] = 6'd3; commit_tag[0] = 5'd2; commit_data[0] = 32'h55;
      tick();
      restore = 1'b1; restore_id = 2'd1;
      tick();
      #2;
      chk("x3_restore_valid", 32'(read_valid[2]), 32'd1);
      chk("x3_restore_data", read_data[2], 32'h55);
      chk("slot1_freed", 32'(ckpt_valid[1]), 32'd0);
      // younger slot invalidated, same-cycle allocate discarded
      tick();
      save = 1'b1; save_id = 2'd0;
      tick();
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd9; alloc_tag[0] = 5'd6;
      save = 1'b1; save_id = 2'd1;
      read_addr[3] = 6'd9; read_addr[4] = 6'd10;
      tick();
      restore = 1'b1; restore_id = 2'd0;
      alloc_en[1] = 1'b1; alloc_addr[1] = 6'd10; alloc_tag[1] = 5'd7;
      tick();
      #2;
      chk("x9_restored_valid", 32'(read_valid[3]), 32'd1);
      chk("x10_alloc_dropped", 32'(read_valid[4]), 32'd1);
      chk("ckv_after_restore0", 32'(ckpt_valid), 32'b0000);
      // invalid restore, then flush with pending allocate
      tick();
      save = 1'b1; save_id = 2'd3;
      tick();
      restore = 1'b1; restore_id = 2'd2;
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd11; alloc_tag[0] = 5'd3;
      read_addr[5] = 6'd11;
      tick();
      #2;
      chk("restore_error_pulse", 32'(restore_error), 32'd1);
      chk("x11_alloc_kept", 32'(read_valid[5]), 32'd0);
      chk("ckv_unchanged", 32'(ckpt_valid), 32'b1000);
      tick();
      #2;
      chk("restore_error_clear", 32'(restore_error), 32'd0);
      flush = 1'b1;
      alloc_en[1] = 1'b1; alloc_addr[1] = 6'd12; alloc_tag[1] = 5'd1;
      read_addr[0] = 6'd12;
      tick();
      #2;
      chk("flush_x12_valid", 32'(read_valid[0]), 32'd1);
      chk("flush_x11_valid", 32'(read_valid[5]), 32'd1);
      chk("flush_x7_valid", 32'(read_valid[1]), 32'd1);
      chk("flush_ckv", 32'(ckpt_valid), 32'b0000);
      // age ordering, release vs save
      tick(); save = 1'b1; save_id = 2'd0;
      tick(); save = 1'b1; save_id = 2'd1;
      tick(); save = 1'b1; save_id = 2'd2;
      tick(); restore = 1'b1; restore_id = 2'd1;
      tick();
      #2;
      chk("age_restore1_ckv", 32'(ckpt_valid), 32'b0001);
      tick();
      save = 1'b1; save_id = 2'd0; release_c = 1'b1; release_id = 2'd0;
      tick();
      #2;
      chk("save_beats_release", 32'(ckpt_valid), 32'b0001);
      release_c = 1'b1; release_id = 2'd0;
      tick();
      #2;
      chk("release_clears", 32'(ckpt_valid), 32'b0000);
      // register 0 ignores writes
      tick();
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd0; alloc_tag[0] = 5'd1;
      commit_en[0] = 1'b1; commit_addr[0] = 6'd0; commit_tag[0] = 5'd0; commit_data[0] = 32'hFF;
      read_addr[0] = 6'd0;
      #2;
      chk("x0_fwd_data", read_data[0], 32'h0);
      chk("x0_fwd_valid", 32'(read_valid[0]), 32'd1);
      chk("x0_fwd_tag", 32'(read_tag[0]), 32'd0);
      tick();
      #2;
      chk("x0_data", read_data[0], 32'h0);
      chk("x0_valid", 32'(read_valid[0]), 32'd1);
      // asynchronous reset in the middle of a restore
      tick();
      save = 1'b1; save_id = 2'd0;
      read_addr[0] = 6'd5; read_addr[1] = 6'd13;
      tick();
      restore = 1'b1; restore_id = 2'd0;
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd13; alloc_tag[0] = 5'd2;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ckv", 32'(ckpt_valid), 32'b0000);
      chk("rst_x5_data", read_data[0], 32'h0);
      chk("rst_x5_valid", 32'(read_valid[0]), 32'd1);
      chk("rst_restore_error", 32'(restore_error), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tagged_checkpoint_register_file.md
# tagged_checkpoint_register_file

Parametrised successor to the dispatch-stage multi-port register file. It holds architectural/physical register data alongside a per-register valid bit and producer tag, where the tag is a full ROB index rather than an ALU id. It supports configurable read, allocate and commit port counts. Checkpoint save/restore of the valid+tag map provides single-cycle branch-mispredict recovery, plus a global flush. It sits in the dispatch stage between rename/decode (allocate, read) and the ROB (commit, recovery).

## Interface
- DATA_WIDTH, 32, register data width
- NUM_REGISTERS, 64, register count; register 0 hardwired
- ADDR_WIDTH, $clog2(NUM_REGISTERS), address width
- NUM_READ_PORTS, 6, combinational read ports
- NUM_ALLOC_PORTS, 3, allocate ports; a higher index is younger in program order
- NUM_COMMIT_PORTS, 3, ROB commit ports
- TAG_WIDTH, 5, producer tag width (ROB index)
- NUM_CHECKPOINTS, 4, checkpoint slots; CKPT_W = $clog2(NUM_CHECKPOINTS)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- read_addr  in  [NUM_READ_PORTS][ADDR_WIDTH]  read addresses
- read_data  out  [NUM_READ_PORTS][DATA_WIDTH]  read data
- read_valid  out  [NUM_READ_PORTS]  1 = data is final
- read_tag  out  [NUM_READ_PORTS][TAG_WIDTH]  producer tag; meaningful only when read_valid=0
- alloc_enable  in  [NUM_ALLOC_PORTS]  allocate a destination
- alloc_addr  in  [NUM_ALLOC_PORTS][ADDR_WIDTH]  destination register
- alloc_tag  in  [NUM_ALLOC_PORTS][TAG_WIDTH]  producer ROB index
- commit_enable  in  [NUM_COMMIT_PORTS]  commit a result
- commit_addr  in  [NUM_COMMIT_PORTS][ADDR_WIDTH]  destination; distinct across active ports (guaranteed by ROB)
- commit_tag  in  [NUM_COMMIT_PORTS][TAG_WIDTH]  committing ROB index
- commit_data  in  [NUM_COMMIT_PORTS][DATA_WIDTH]  result
- ckpt_save  in  1  save map into slot ckpt_save_id
- ckpt_save_id  in  CKPT_W  target slot
- ckpt_restore  in  1  restore map from slot ckpt_restore_id
- ckpt_restore_id  in  CKPT_W  source slot
- ckpt_release  in  1  invalidate slot ckpt_release_id (branch resolved correctly)
- ckpt_release_id  in  CKPT_W  slot to free
- flush_all  in  1  mark all registers valid, invalidate all checkpoints
- ckpt_valid  out  NUM_CHECKPOINTS  registered slot-occupied flags
- restore_error  out  1  registered one-cycle pulse: restore of an invalid slot

## Operation
- State per register: data, valid, tag. Per checkpoint: valid[], tag[] maps plus the ckpt_valid bit.
- Register 0: always reads data 0, valid 1, tag 0. Allocates and commits to it are ignored.
- Allocate: valid←0, tag←alloc_tag. If several ports target the same address, the highest port index wins.
- Commit: data←commit_data unconditionally. valid←1 only if the stored tag equals commit_tag and no same-cycle allocate targets that address. A tag mismatch is a WAW case: a younger producer owns the register, so valid stays 0.
- Commit also updates every valid checkpoint: in each slot whose saved tag for commit_addr equals commit_tag, the saved valid bit is set to 1.
- Same-cycle allocate and commit to the same address: tag and valid come from the allocate; data comes from the commit.
- ckpt_save captures the next-state map, i.e. after this cycle's allocates and commits, and sets ckpt_valid[id]. Saving into an occupied slot overwrites it.
- ckpt_restore with a valid slot:
  - Next cycle's map equals the checkpoint map, with this cycle's commits applied to it (tag-match rule against the checkpoint tags).
  - This cycle's allocates are discarded; data writes still happen.
  - ckpt_valid is cleared for the restored slot and for every slot saved after it (the front end supplies younger slots in allocation order; the block tracks save order with an age matrix).
  - A same-cycle ckpt_save is ignored.
- ckpt_restore with an invalid slot: no map change; allocates proceed normally; restore_error=1 for one cycle.
- ckpt_release clears ckpt_valid[id]. If ckpt_save in the same cycle names the same id, the save wins.
- flush_all: all valid←1, all ckpt_valid←0. It overrides allocates, restore, save and release. Commits still write data.
- Precedence, highest first: flush_all > ckpt_restore > ckpt_save > ckpt_release; allocates are gated by flush_all and by a valid restore.

## Timing
- Reads are combinational with same-cycle forwarding, in priority order:
  1. address 0
  2. matching allocate (highest port): valid 0, tag = alloc_tag, data = stored or committing data
  3. matching commit: data = commit_data; valid = 1 if tag matches, else stored valid
  4. stored value
- Restore and flush do not forward; their effect is visible from the next cycle.
- All writes are visible to reads one cycle later.
- Reset (asynchronous, active-low): all data 0, valid 1, tag 0; all checkpoint maps valid 1, tag 0; ckpt_valid 0; restore_error 0. Reset asserted mid-operation aborts everything immediately.
- Restore has single-cycle latency. No back-pressure; every request is accepted in the cycle it is asserted.

## Test plan
- Reset, then read x5 -> data 0, valid 1, tag 0. Commit x5=0xDEADBEEF tag 3 with no prior allocate (stored tag 0) -> next cycle data 0xDEADBEEF, valid 1 (never invalidated).
- Allocate x7 tag 4 on port 0 and x7 tag 9 on port 2 in the same cycle -> same-cycle read shows valid 0, tag 9. Next cycle commit x7 tag 4 data 0x11 -> data 0x11, valid stays 0, tag 9.
- Allocate x3 tag 2 with ckpt_save id 1 -> slot 1 holds x3 valid 0 tag 2. Commit x3 tag 2 data 0x55, then restore id 1 -> x3 valid 1, data 0x55.
- Save id 0, allocate x9 tag 6, save id 1, then restore id 0 -> x9 valid 1; ckpt_valid 0b0000; same-cycle allocate of x10 discarded (x10 still valid).
- Restore id 2 while ckpt_valid[2]=0 -> restore_error pulses 1 for one cycle; map unchanged. flush_all with allocates pending -> all valid 1, ckpt_valid 0.
- Write attempts to x0 (allocate tag 1, commit 0xFF) -> x0 reads 0, valid 1. Assert reset mid-restore -> all outputs return to reset values immediately.
